serial_adder_ctrl: RTL

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl_pkg.sv | 15 +
 rtl/serial_adder_ctrl_adder.sv | 14 +
 rtl/serial_adder_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and helpers for the chunk-serial adder controller.
package serial_adder_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter width that stays legal when only one chunk exists.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_adder.sv
// Combinational DATASIZE-bit adder with carry in/out; the only adder in the block.
module serial_adder_ctrl_adder #(
   parameter int DATASIZE = 8
) (
   input  logic [DATASIZE-1:0] a_i,
   input  logic [DATASIZE-1:0] b_i,
   input  logic                carryin_i,
   output logic [DATASIZE-1:0] result_o,
   output logic                carryout_o
);

   assign {carryout_o, result_o} = {1'b0, a_i} + {1'b0, b_i} + {{DATASIZE{1'b0}}, carryin_i};

endmodule

// File: rtl/serial_adder_ctrl.sv
// Adds two W-bit operands one DATASIZE chunk per cycle through a single shared adder.
// Optional overflow flag output: define SERIAL_ADDER_CTRL_OVERFLOW_EN.
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int DATASIZE  = 8,
   parameter int NB_CHUNKS = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic [DATASIZE*NB_CHUNKS-1:0] a_i,
   input  logic [DATASIZE*NB_CHUNKS-1:0] b_i,
   input  logic                          carry_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [DATASIZE*NB_CHUNKS-1:0] result_o,
`ifdef SERIAL_ADDER_CTRL_OVERFLOW_EN
   output logic                          carry_o,
   output logic                          overflow_o
`else
   output logic                          carry_o
`endif
);

   localparam int             CW     = cnt_w(NB_CHUNKS);
   localparam logic [CW-1:0]  K_LAST = CW'(NB_CHUNKS - 1);

   state_t                               state;
   logic [NB_CHUNKS-1:0][DATASIZE-1:0]   a_q;
   logic [NB_CHUNKS-1:0][DATASIZE-1:0]   b_q;
   logic [NB_CHUNKS-1:0][DATASIZE-1:0]   res_q;
   logic                                 carry_q;
   logic [CW-1:0]                        k;
   logic [DATASIZE-1:0]                  sum;
   logic                                 cout;

   serial_adder_ctrl_adder #(
      .DATASIZE (DATASIZE)
   ) u_adder (
      .a_i        (a_q[k]),
      .b_i        (b_q[k]),
      .carryin_i  (carry_q),
      .result_o   (sum),
      .carryout_o (cout)
   );

   // The carry register doubles as carry-in for chunk 0 and carry-out once done.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state   <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         k       <= '0;
      end else begin
         unique case (state)
            IDLE: if (in_valid_i) begin
               a_q     <= a_i;
               b_q     <= b_i;
               carry_q <= carry_i;
               k       <= '0;
               state   <= RUN;
            end
            RUN: begin
               res_q[k] <= sum;
               carry_q  <= cout;
               k        <= k + 1'b1;
               if (k == K_LAST) state <= DONE;
            end
            DONE: if (out_ready_i) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SERIAL_ADDER_CTRL_OVERFLOW_EN
   logic ovf_q;

   // Two's-complement overflow: equal operand signs, result sign differs.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ovf_q <= 1'b0;
      end else if (state == RUN && k == K_LAST) begin
         ovf_q <= (a_q[NB_CHUNKS-1][DATASIZE-1] == b_q[NB_CHUNKS-1][DATASIZE-1]) &&
                  (sum[DATASIZE-1] != a_q[NB_CHUNKS-1][DATASIZE-1]);
      end
   end

   assign overflow_o = ovf_q;
`endif

   assign in_ready_o  = (state == IDLE);
   assign out_valid_o = (state == DONE);
   assign result_o    = res_q;
   assign carry_o     = carry_q;

endmodule
